// File: rtl/register_wb_arbiter.sv
// Register-file writeback arbiter: two 2-deep requester FIFOs, round-robin grant, registered write port.
// Per-register in-flight tracking on wb_pending_o is built only when REGWB_PENDING_EN is defined.
module register_wb_arbiter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        a_valid_i,
   input  logic [4:0]  a_waddr_i,
   input  logic [31:0] a_wdata_i,
   output logic        a_ready_o,
   input  logic        b_valid_i,
   input  logic [4:0]  b_waddr_i,
   input  logic [31:0] b_wdata_i,
   output logic        b_ready_o,
   output logic        wren_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] wdata_o,
   output logic [31:0] wb_pending_o
);

   localparam int unsigned NP    = 2;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   logic [NP-1:0] valid, push, pop;
   logic [NP-1:0] ready_q, ready_d;
   logic [AW-1:0] in_addr [NP];
   logic [DW-1:0] in_data [NP];
   logic [1:0]    cnt_q [NP];
   logic [1:0]    cnt_d [NP];
   logic [AW-1:0] addr_q [NP][DEPTH];
   logic [AW-1:0] addr_d [NP][DEPTH];
   logic [DW-1:0] data_q [NP][DEPTH];
   logic [DW-1:0] data_d [NP][DEPTH];
   logic          prio_b_q, prio_b_d;
   logic          gnt_valid, gnt_sel;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          wren_q, wren_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   assign valid      = {b_valid_i, a_valid_i};
   assign in_addr[0] = a_waddr_i;
   assign in_addr[1] = b_waddr_i;
   assign in_data[0] = a_wdata_i;
   assign in_data[1] = b_wdata_i;
   assign push       = valid & ready_q;

   // Grant: the only non-empty head, else the port not granted last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = 1'b0;
      if (cnt_q[0] != 2'd0 && cnt_q[1] != 2'd0) begin
         gnt_valid = 1'b1;
         gnt_sel   = prio_b_q;
      end else if (cnt_q[0] != 2'd0) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b0;
      end else if (cnt_q[1] != 2'd0) begin
         gnt_valid = 1'b1;
         gnt_sel   = 1'b1;
      end
   end

   assign pop       = {gnt_valid & gnt_sel, gnt_valid & ~gnt_sel};
   assign head_addr = addr_q[gnt_sel][0];
   assign head_data = data_q[gnt_sel][0];
   assign prio_b_d  = gnt_valid ? ~gnt_sel : prio_b_q;

   // FIFO update: pop shifts entry 1 down, push lands just after the surviving entries.
   always_comb begin
      ready_d = '0;
      for (int p = 0; p < NP; p++) begin
         cnt_d[p]  = cnt_q[p];
         addr_d[p] = addr_q[p];
         data_d[p] = data_q[p];
         if (pop[p]) begin
            addr_d[p][0] = addr_q[p][1];
            data_d[p][0] = data_q[p][1];
         end
         if (push[p]) begin
            if (cnt_q[p] == 2'd0 || (cnt_q[p] == 2'd1 && pop[p])) begin
               addr_d[p][0] = in_addr[p];
               data_d[p][0] = in_data[p];
            end else begin
               addr_d[p][1] = in_addr[p];
               data_d[p][1] = in_data[p];
            end
         end
         cnt_d[p]   = cnt_q[p] + 2'(push[p]) - 2'(pop[p]);
         ready_d[p] = (cnt_d[p] < 2'(DEPTH));
      end
   end

   // Register x0 is granted like any other write but never enables the write port.
   always_comb begin
      wren_d  = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (gnt_valid) begin
         wren_d  = (head_addr != '0);
         waddr_d = head_addr;
         wdata_d = head_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < NP; p++) begin
            cnt_q[p] <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               addr_q[p][e] <= '0;
               data_q[p][e] <= '0;
            end
         end
         ready_q  <= '0;
         prio_b_q <= 1'b0;
         wren_q   <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         ready_q  <= ready_d;
         prio_b_q <= prio_b_d;
         wren_q   <= wren_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign a_ready_o = ready_q[0];
   assign b_ready_o = ready_q[1];
   assign wren_o    = wren_q;
   assign waddr_o   = waddr_q;
   assign wdata_o   = wdata_q;

`ifdef REGWB_PENDING_EN
   localparam int unsigned NREG = 32;

   logic [NREG-1:0] pend_q, pend_d;

   // Pending map built from next-state contents so it lines up with the registered outputs.
   always_comb begin
      pend_d = '0;
      for (int p = 0; p < NP; p++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (cnt_d[p] > 2'(e)) begin
               pend_d[addr_d[p][e]] = 1'b1;
            end
         end
      end
      if (wren_d) begin
         pend_d[waddr_d] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign wb_pending_o = pend_q;
`else
   assign wb_pending_o = '0;
`endif

endmodule

// File: tb/tb_register_wb_arbiter.sv
// Bench for register_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
// Pending-map expectations follow REGWB_PENDING_EN as seen by this compile.
module tb_register_wb_arbiter;

`ifdef REGWB_PENDING_EN
   localparam bit PEND_EN = 1'b1;
`else
   localparam bit PEND_EN = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        a_valid = 1'b0;
   logic [4:0]  a_waddr = '0;
   logic [31:0] a_wdata = '0;
   logic        a_ready;
   logic        b_valid = 1'b0;
   logic [4:0]  b_waddr = '0;
   logic [31:0] b_wdata = '0;
   logic        b_ready;
   logic        wren;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] wb_pending;

   always #5 clk = ~clk;

   register_wb_arbiter dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .a_valid_i    (a_valid),
      .a_waddr_i    (a_waddr),
      .a_wdata_i    (a_wdata),
      .a_ready_o    (a_ready),
      .b_valid_i    (b_valid),
      .b_waddr_i    (b_waddr),
      .b_wdata_i    (b_wdata),
      .b_ready_o    (b_ready),
      .wren_o       (wren),
      .waddr_o      (waddr),
      .wdata_o      (wdata),
      .wb_pending_o (wb_pending)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: per-requester queues, last-granted port and the expected write port.
   ent_t        qa[$];
   ent_t        qb[$];
   bit          m_ready_a, m_ready_b, m_prio_b, m_wren;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_pend();
      logic [31:0] p = '0;
      if (PEND_EN) begin
         foreach (qa[i]) p[qa[i].a] = 1'b1;
         foreach (qb[i]) p[qb[i].a] = 1'b1;
         if (m_wren) p[m_waddr] = 1'b1;
         p[0] = 1'b0;
      end
      return p;
   endfunction

   task automatic model_reset();
      qa.delete();
      qb.delete();
      m_ready_a = 1'b0;
      m_ready_b = 1'b0;
      m_prio_b  = 1'b0;
      m_wren    = 1'b0;
      m_waddr   = '0;
      m_wdata   = '0;
   endtask

   // One rising edge of the model, using the inputs currently driven.
   task automatic model_edge();
      bit   has_a, has_b, sel;
      ent_t e;
      has_a  = (qa.size() != 0);
      has_b  = (qb.size() != 0);
      sel    = (has_a && has_b) ? m_prio_b : has_b;
      m_wren = 1'b0;
      if (has_a || has_b) begin
         e        = sel ? qb.pop_front() : qa.pop_front();
         m_wren   = (e.a != 5'd0);
         m_waddr  = e.a;
         m_wdata  = e.d;
         m_prio_b = !sel;
      end
      if (a_valid && m_ready_a) qa.push_back(ent_t'{a_waddr, a_wdata});
      if (b_valid && m_ready_b) qb.push_back(ent_t'{b_waddr, b_wdata});
      m_ready_a = (qa.size() < 2);
      m_ready_b = (qb.size() < 2);
   endtask

   task automatic check_outputs();
      check("a_ready", 32'(a_ready), 32'(m_ready_a));
      check("b_ready", 32'(b_ready), 32'(m_ready_b));
      check("wren", 32'(wren), 32'(m_wren));
      if (m_wren) begin
         check("waddr", 32'(waddr), 32'(m_waddr));
         check("wdata", wdata, m_wdata);
      end
      check("wb_pending", wb_pending, exp_pend());
   endtask

   // Called at a falling edge: check this cycle, advance model and DUT by one edge.
   task automatic tick();
      check_outputs();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_a_ready"}, 32'(a_ready), 32'd0);
      check({tag, "_b_ready"}, 32'(b_ready), 32'd0);
      check({tag, "_wren"}, 32'(wren), 32'd0);
      check({tag, "_waddr"}, 32'(waddr), 32'd0);
      check({tag, "_wdata"}, wdata, 32'd0);
      check({tag, "_pending"}, wb_pending, 32'd0);
   endtask

   task automatic reset_pulse();
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_ni  = 1'b0;
      #1;
      model_reset();
      check_reset("rst_async");
      @(negedge clk);
      check_reset("rst_held");
      rst_ni = 1'b1;
   endtask

   initial begin
      int  acnt, bcnt;
      bit  pa, pb;
      @(negedge clk);
      reset_pulse();

      // Single write to x5: two-cycle latency, one pulse.
      tick();
      a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 32'h1111_1111;
      tick();
      a_valid = 1'b0;
      tick();
      check("x5_wren", 32'(wren), 32'd1);
      check("x5_waddr", 32'(waddr), 32'd5);
      check("x5_wdata", wdata, 32'h1111_1111);
      tick();
      check("x5_single_pulse", 32'(wren), 32'd0);
      tick();

      // Both requesters streaming: alternate A,B starting with A, write port never idle.
      reset_pulse();
      tick();
      acnt = 1; bcnt = 17;
      for (int i = 0; i < 12; i++) begin
         a_valid = 1'b1; a_waddr = 5'(acnt); a_wdata = 32'hA000_0000 + 32'(acnt);
         b_valid = 1'b1; b_waddr = 5'(bcnt); b_wdata = 32'hB000_0000 + 32'(bcnt);
         if (i == 2) check("alt_first_a", 32'(waddr), 32'd1);
         if (i == 3) check("alt_then_b", 32'(waddr), 32'd17);
         if (i == 4) check("alt_second_a", 32'(waddr), 32'd2);
         if (i == 5) check("alt_second_b", 32'(waddr), 32'd18);
         if (i >= 2) check("alt_wren_held", 32'(wren), 32'd1);
         pa = m_ready_a;
         pb = m_ready_b;
         tick();
         if (pa) acnt++;
         if (pb) bcnt++;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (6) tick();

      // B-only stream: never back-pressured, order kept.
      reset_pulse();
      tick();
      for (int i = 0; i < 4; i++) begin
         b_valid = 1'b1; b_waddr = 5'(9 + i); b_wdata = 32'hB0B0_0000 + 32'(i);
         check("b_only_ready", 32'(b_ready), 32'd1);
         if (i == 2) check("b_only_first", 32'(waddr), 32'd9);
         if (i == 3) check("b_only_second", 32'(waddr), 32'd10);
         if (i >= 2) check("b_only_wren", 32'(wren), 32'd1);
         tick();
      end
      b_valid = 1'b0;
      check("b_only_third", 32'(waddr), 32'd11);
      check("b_only_wren3", 32'(wren), 32'd1);
      tick();
      check("b_only_fourth", 32'(waddr), 32'd12);
      check("b_only_fourth_data", wdata, 32'hB0B0_0003);
      tick();
      check("b_only_done", 32'(wren), 32'd0);

      // Write to x0: accepted, never written, never pending.
      a_valid = 1'b1; a_waddr = 5'd0; a_wdata = 32'hDEAD_BEEF;
      check("x0_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("x0_wren", 32'(wren), 32'd0);
         check("x0_pending", wb_pending, 32'd0);
         tick();
      end

      // Same-address collision on x7: A's value first, then B's.
      reset_pulse();
      tick();
      a_valid = 1'b1; a_waddr = 5'd7; a_wdata = 32'h1;
      b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'h2;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      check("x7_queued_pend", 32'(wb_pending[7]), 32'(PEND_EN));
      tick();
      check("x7_first_wren", 32'(wren), 32'd1);
      check("x7_first_addr", 32'(waddr), 32'd7);
      check("x7_first_data", wdata, 32'h1);
      check("x7_first_pend", 32'(wb_pending[7]), 32'(PEND_EN));
      tick();
      check("x7_second_wren", 32'(wren), 32'd1);
      check("x7_second_data", wdata, 32'h2);
      check("x7_second_pend", 32'(wb_pending[7]), 32'(PEND_EN));
      tick();
      check("x7_done_wren", 32'(wren), 32'd0);
      check("x7_done_pend", 32'(wb_pending[7]), 32'd0);

      // Reset while both FIFOs hold writes: everything discarded.
      reset_pulse();
      tick();
      for (int i = 0; i < 5; i++) begin
         a_valid = 1'b1; a_waddr = 5'($urandom_range(1, 31)); a_wdata = $urandom;
         b_valid = 1'b1; b_waddr = 5'($urandom_range(1, 31)); b_wdata = $urandom;
         tick();
      end
      reset_pulse();
      for (int i = 0; i < 4; i++) begin
         check("post_rst_no_wren", 32'(wren), 32'd0);
         tick();
      end

      // Random traffic, including x0 and occasional resets.
      for (int i = 0; i < 400; i++) begin
         a_valid = ($urandom_range(0, 99) < 55);
         a_waddr = 5'($urandom_range(0, 31));
         a_wdata = $urandom;
         b_valid = ($urandom_range(0, 99) < 55);
         b_waddr = 5'($urandom_range(0, 31));
         b_wdata = $urandom;
         if ($urandom_range(0, 149) == 0) reset_pulse();
         else tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (6) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/register_wb_arbiter.md
REGISTER_WB_ARBITER -- requirements
Module: register_wb_arbiter

Interface
REQ-001 rst  input  1  reset; asynchronous, active-low.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 a_valid  input  1  requester A (pipeline writeback) has a write.
REQ-004 a_waddr  input  5  requester A destination register.
REQ-005 a_wdata  input  32  requester A write data.
REQ-006 a_ready  output  1  requester A may transfer; registered, no combinational path from any input.
REQ-007 b_valid / b_waddr / b_wdata / b_ready  same widths and meanings as REQ-003..006, for requester B (long-latency unit).
REQ-008 wren  output  1  register-file write enable; registered.
REQ-009 waddr  output  5  register-file write address; registered.
REQ-010 wdata  output  32  register-file write data; registered.
REQ-011 wb_pending  output  32  one bit per register with a write in flight.

Function
REQ-012 Transfer on a requester port SHALL occur at a rising edge where valid=1 and ready=1; waddr/wdata SHALL be captured at that edge.
REQ-013 Each requester port SHALL own a 2-entry FIFO; ready=1 iff its count<2 at the start of the cycle.
REQ-014 The FIFO SHALL pop its head at the same edge it pushes; a push to a count-1 FIFO with a simultaneous pop SHALL leave count 1.
REQ-015 Each cycle, one non-empty FIFO head SHALL be granted; if only one FIFO is non-empty, it SHALL be granted.
REQ-016 If both FIFOs are non-empty, the grant SHALL go to the FIFO not granted last; the priority pointer SHALL update only on a grant.
REQ-017 A granted head SHALL load the output register at the next edge: wren=1, waddr and wdata = the head entry, for exactly one cycle unless another grant follows.
REQ-018 If no grant occurs in a cycle, wren SHALL be 0 in the following cycle; waddr/wdata SHALL hold their previous values.
REQ-019 Latency SHALL be 2 cycles: transfer at edge N into an empty FIFO with no competing entry gives wren=1 in the cycle after edge N+1.
REQ-020 Aggregate throughput SHALL be one write per cycle; per-requester order SHALL be preserved.
REQ-021 A write to address 0 SHALL be accepted and granted normally, but SHALL produce wren=0.
REQ-022 Same-address writes from A and B SHALL be presented in grant order; the later grant wins in the register file.
REQ-023 wb_pending[i] SHALL be 1 iff register i (i != 0) is held in either FIFO or in the output register with wren=1; wb_pending[0] SHALL always be 0.

Reset
REQ-024 While rst=0: FIFO counts=0, a_ready=b_ready=0, wren=0, waddr=0, wdata=0, wb_pending=0, and the priority pointer SHALL select A first.
REQ-025 Assertion mid-operation SHALL discard all buffered and in-flight writes without further wren pulses; a_ready/b_ready SHALL rise in the first cycle after the first edge following deassertion.

Configuration
REQ-026 Macro REGWB_PENDING_EN: when defined, wb_pending SHALL be computed per REQ-023.
REQ-027 When REGWB_PENDING_EN is undefined, wb_pending SHALL be constant 0 and no tracking logic SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset release, A writes x5=0x11111111 once -> wren=1, waddr=5, wdata=0x11111111 two cycles after transfer; a single pulse.
REQ-029 A and B valid every cycle with distinct addresses, both FIFOs non-empty -> grants alternate A,B,A,B starting with A after reset; wren held at 1 continuously.
REQ-030 B valid for 4 cycles while A idle and wren continuously 1 -> b_ready stays 1; a B-only stream is not starved and order is kept.
REQ-031 A writes x0=0xDEADBEEF -> a_ready behaves normally, wren stays 0, wb_pending stays 0.
REQ-032 A and B both write x7 in the same cycle (A=0x1, B=0x2) with pointer at A -> wren pulses x7=0x1 then x7=0x2; wb_pending[7]=1 until the second pulse ends.
REQ-033 rst asserted while both FIFOs are full -> outputs reach reset values immediately, no wren after release until new transfers.
